// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: byte-addressable little-endian data memory with sized, extended loads,
// configurable wait states behind a ready/valid stall, branch resolution and fault reporting.
module mem_stage_lsu #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_MEM_SIZE = 1024,
    parameter int WAIT_STATES   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_size,
    input  logic                  load_unsigned,
    input  logic                  branch,
    input  logic [1:0]            branch_type,
    input  logic                  zero,
    input  logic                  negative,
    input  logic [4:0]            rd_in,
    input  logic [DATA_WIDTH-1:0] ALU_result_in,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  PCSrc,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] ALU_result_out,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  mem_to_reg_out,
    output logic                  reg_write_out,
    output logic [4:0]            rd_out,
    output logic                  mem_fault
);
    localparam int IDX_W = (DATA_MEM_SIZE > 1) ? $clog2(DATA_MEM_SIZE) : 1;
    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [DATA_WIDTH-1:0]   lat_alu_q, lat_wdata_q;
    logic [1:0]              lat_size_q;
    logic                    lat_uns_q, lat_read_q, lat_write_q, lat_rw_q, lat_m2r_q;
    logic [4:0]              lat_rd_q;
    logic                    valid_q, m2r_q, rw_q, fault_q;
    logic [DATA_WIDTH-1:0]   alu_out_q, rdata_q;
    logic [4:0]              rd_q;
    logic [7:0]              mem_q [DATA_MEM_SIZE];

    logic                    accept_s, is_mem_s, use_lat_s, complete_s, start_wait_s, cond_s;
    logic [DATA_WIDTH-1:0]   op_alu_s, op_wdata_s;
    logic [1:0]              op_size_s;
    logic                    op_uns_s, op_read_s, op_write_s, op_rw_s, op_m2r_s, op_is_mem_s;
    logic [4:0]              op_rd_s;
    logic [ADDR_WIDTH-1:0]   op_addr_s;
    logic [2:0]              nbytes_s;
    logic                    size_bad_s, fault_s, in_range_s, we_s;
    logic [31:0]             end_addr_s, ext_s, wdata32_s;
    logic [IDX_W-1:0]        idx_s [4];
    logic [7:0]              rbyte_s [4];
    logic [DATA_WIDTH-1:0]   load_val_s;

    assign ready_out    = (state_q == S_IDLE);
    assign accept_s     = valid_in & ready_out;
    assign is_mem_s     = mem_read | mem_write;
    assign use_lat_s    = (state_q == S_WAIT);
    assign complete_s   = (accept_s & (~is_mem_s | (WAIT_STATES == 0))) | (use_lat_s & (cnt_q == 4'd1));
    assign start_wait_s = accept_s & is_mem_s & (WAIT_STATES != 0);

    // While stalled, the access is driven purely from the latched instruction.
    assign op_alu_s    = use_lat_s ? lat_alu_q   : ALU_result_in;
    assign op_wdata_s  = use_lat_s ? lat_wdata_q : write_data;
    assign op_size_s   = use_lat_s ? lat_size_q  : mem_size;
    assign op_uns_s    = use_lat_s ? lat_uns_q   : load_unsigned;
    assign op_read_s   = use_lat_s ? lat_read_q  : mem_read;
    assign op_write_s  = use_lat_s ? lat_write_q : mem_write;
    assign op_rw_s     = use_lat_s ? lat_rw_q    : reg_write_in;
    assign op_m2r_s    = use_lat_s ? lat_m2r_q   : mem_to_reg_in;
    assign op_rd_s     = use_lat_s ? lat_rd_q    : rd_in;
    assign op_is_mem_s = op_read_s | op_write_s;
    assign op_addr_s   = op_alu_s[ADDR_WIDTH-1:0];
    assign wdata32_s   = 32'(op_wdata_s);

    // Branch condition select.
    always_comb begin
        cond_s = 1'b0;
        case (branch_type)
            2'd0:    cond_s = zero;
            2'd1:    cond_s = ~zero;
            2'd2:    cond_s = negative;
            2'd3:    cond_s = ~negative;
            default: cond_s = 1'b0;
        endcase
    end

    assign PCSrc = accept_s & branch & cond_s;

    // Access size and alignment legality.
    always_comb begin
        nbytes_s   = 3'd1;
        size_bad_s = 1'b0;
        case (op_size_s)
            2'd0: begin
                nbytes_s   = 3'd1;
                size_bad_s = 1'b0;
            end
            2'd1: begin
                nbytes_s   = 3'd2;
                size_bad_s = op_addr_s[0];
            end
            2'd2: begin
                nbytes_s   = 3'd4;
                size_bad_s = (op_addr_s[1:0] != 2'b00) || (DATA_WIDTH == 16);
            end
            default: begin
                nbytes_s   = 3'd1;
                size_bad_s = 1'b1;
            end
        endcase
    end

    assign fault_s    = op_is_mem_s & size_bad_s;
    assign end_addr_s = 32'(op_addr_s) + 32'(nbytes_s);
    assign in_range_s = (end_addr_s <= 32'(DATA_MEM_SIZE));
    assign we_s       = complete_s & op_write_s & ~fault_s & in_range_s;

    // Little-endian byte lanes; lanes beyond the access size or out of range read as zero.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            idx_s[i]   = IDX_W'(32'(op_addr_s) + 32'(i));
            rbyte_s[i] = ((32'(i) < 32'(nbytes_s)) && in_range_s) ? mem_q[idx_s[i]] : 8'h00;
        end
    end

    // Sign or zero extension of the assembled load value.
    always_comb begin
        ext_s = 32'h0000_0000;
        case (op_size_s)
            2'd0:    ext_s = {{24{~op_uns_s & rbyte_s[0][7]}}, rbyte_s[0]};
            2'd1:    ext_s = {{16{~op_uns_s & rbyte_s[1][7]}}, rbyte_s[1], rbyte_s[0]};
            default: ext_s = {rbyte_s[3], rbyte_s[2], rbyte_s[1], rbyte_s[0]};
        endcase
    end

    assign load_val_s = (op_read_s & ~op_write_s & ~fault_s) ? ext_s[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};

    // Data memory write port; contents survive reset, and a low reset blocks the write.
    always_ff @(posedge clock) begin
        if (we_s && reset) begin
            for (int i = 0; i < 4; i++) begin
                if (32'(i) < 32'(nbytes_s)) begin
                    mem_q[idx_s[i]] <= wdata32_s[8*i +: 8];
                end
            end
        end
    end

    // Stall FSM, instruction latch and MEM/WB output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            lat_alu_q   <= {DATA_WIDTH{1'b0}};
            lat_wdata_q <= {DATA_WIDTH{1'b0}};
            lat_size_q  <= 2'd0;
            lat_uns_q   <= 1'b0;
            lat_read_q  <= 1'b0;
            lat_write_q <= 1'b0;
            lat_rw_q    <= 1'b0;
            lat_m2r_q   <= 1'b0;
            lat_rd_q    <= 5'd0;
            valid_q     <= 1'b0;
            alu_out_q   <= {DATA_WIDTH{1'b0}};
            rdata_q     <= {DATA_WIDTH{1'b0}};
            m2r_q       <= 1'b0;
            rw_q        <= 1'b0;
            rd_q        <= 5'd0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_wait_s) begin
                        state_q     <= S_WAIT;
                        cnt_q       <= WS_CNT;
                        lat_alu_q   <= ALU_result_in;
                        lat_wdata_q <= write_data;
                        lat_size_q  <= mem_size;
                        lat_uns_q   <= load_unsigned;
                        lat_read_q  <= mem_read;
                        lat_write_q <= mem_write;
                        lat_rw_q    <= reg_write_in;
                        lat_m2r_q   <= mem_to_reg_in;
                        lat_rd_q    <= rd_in;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase

            if (complete_s) begin
                valid_q   <= 1'b1;
                alu_out_q <= op_alu_s;
                rdata_q   <= load_val_s;
                m2r_q     <= op_m2r_s;
                rw_q      <= op_rw_s & ~fault_s;
                rd_q      <= op_rd_s;
                fault_q   <= fault_s;
            end else begin
                valid_q <= 1'b0;
                rw_q    <= 1'b0;
                fault_q <= 1'b0;
            end
        end
    end

    assign valid_out      = valid_q;
    assign ALU_result_out = alu_out_q;
    assign read_data      = rdata_q;
    assign mem_to_reg_out = m2r_q;
    assign reg_write_out  = rw_q;
    assign rd_out         = rd_q;
    assign mem_fault      = fault_q;
endmodule
